// File: rtl/usb_rx_controller_if.sv
// Signal bundle between the USB RX bit datapath / RX FIFO side (master) and the RX control FSM (slave).
// state_dbg carries the FSM state so checkers can observe it without reaching into the design.
interface usb_rx_controller_if;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic       byte_received;
    logic [7:0] rcv_data;
    logic       crc_ok;
    logic       fifo_full;
    logic       rcving;
    logic       w_enable;
    logic       r_error;
    logic [3:0] rx_pid;
    logic       packet_done;
    logic       crc_clear;
    logic       crc_enable;
    logic [6:0] byte_count;
    logic [3:0] state_dbg;

    modport master (
        output d_edge, eop, shift_enable, byte_received, rcv_data, crc_ok, fifo_full,
        input  rcving, w_enable, r_error, rx_pid, packet_done, crc_clear, crc_enable,
               byte_count, state_dbg
    );

    modport slave (
        input  d_edge, eop, shift_enable, byte_received, rcv_data, crc_ok, fifo_full,
        output rcving, w_enable, r_error, rx_pid, packet_done, crc_clear, crc_enable,
               byte_count, state_dbg
    );
endinterface

// File: rtl/usb_rx_controller.sv
// USB full-speed receive control FSM: checks SYNC/PID, writes payload to the RX FIFO, checks CRC at EOP.
// Optional inter-byte strobe timeout is enabled by defining USB_RX_TIMEOUT_EN.
module usb_rx_controller #(
    parameter int         MAX_BYTES    = 64,
    parameter logic [7:0] SYNC_BYTE    = 8'h80
`ifdef USB_RX_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_BITS = 16
`endif
) (
    input  logic                clk,
    input  logic                n_rst,
    usb_rx_controller_if.slave  rx
);
    // Handshake: byte_received is a one-cycle valid with no ready; a byte is always taken and
    // answered by w_enable exactly one cycle later, while fifo_full turns the byte into an error.
    typedef enum logic [3:0] {
        IDLE, SYNC_WAIT, CHK_SYNC, PID_WAIT, CHK_PID, DATA_WAIT,
        STORE, EOP_CHK, DONE, ERR_WAIT_EOP, ERR_IDLE
    } state_t;

    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

    state_t     state_q, state_d;
    logic       rcving_q, rcving_d;
    logic       w_enable_q, w_enable_d;
    logic       r_error_q, r_error_d;
    logic [3:0] rx_pid_q, rx_pid_d;
    logic       packet_done_q, packet_done_d;
    logic       crc_clear_q, crc_clear_d;
    logic       crc_enable_q, crc_enable_d;
    logic [6:0] byte_count_q, byte_count_d;
    logic       tmo_hit;
    logic       in_wait;

    assign in_wait = (state_q == SYNC_WAIT) || (state_q == PID_WAIT) || (state_q == DATA_WAIT);

`ifdef USB_RX_TIMEOUT_EN
    localparam logic [4:0] TMO_LIMIT = 5'(TIMEOUT_BITS);
    logic [4:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = tmo_q;
        if ((state_q == IDLE && rx.d_edge) || rx.byte_received) begin
            tmo_d = '0;
        end else if (rx.shift_enable && in_wait && tmo_q != TMO_LIMIT) begin
            tmo_d = tmo_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end

    assign tmo_hit = in_wait && (tmo_q == TMO_LIMIT);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        w_enable_d   = 1'b0;
        crc_clear_d  = 1'b0;
        r_error_d    = r_error_q;
        rx_pid_d     = rx_pid_q;
        byte_count_d = byte_count_q;

        unique case (state_q)
            IDLE: begin
                if (rx.d_edge) begin
                    state_d      = SYNC_WAIT;
                    byte_count_d = '0;
                end
            end
            SYNC_WAIT: begin
                if (rx.eop)                state_d = ERR_WAIT_EOP;
                else if (rx.byte_received) state_d = CHK_SYNC;
                else if (tmo_hit)          state_d = ERR_WAIT_EOP;
            end
            CHK_SYNC: begin
                if (rx.rcv_data == SYNC_BYTE) begin
                    state_d   = PID_WAIT;
                    r_error_d = 1'b0;
                end else begin
                    state_d = ERR_WAIT_EOP;
                end
            end
            PID_WAIT: begin
                if (rx.eop)                state_d = ERR_WAIT_EOP;
                else if (rx.byte_received) state_d = CHK_PID;
                else if (tmo_hit)          state_d = ERR_WAIT_EOP;
            end
            CHK_PID: begin
                if (rx.rcv_data[7:4] == ~rx.rcv_data[3:0]) begin
                    state_d     = DATA_WAIT;
                    rx_pid_d    = rx.rcv_data[3:0];
                    crc_clear_d = 1'b1;
                end else begin
                    state_d = ERR_WAIT_EOP;
                end
            end
            DATA_WAIT: begin
                if (rx.eop) begin
                    state_d = EOP_CHK;
                end else if (rx.byte_received) begin
                    // Write decision is taken here so w_enable can leave a flop during STORE.
                    state_d = STORE;
                    if (!rx.fifo_full && byte_count_q != MAX_CNT) begin
                        w_enable_d   = 1'b1;
                        byte_count_d = byte_count_q + 7'd1;
                    end
                end else if (tmo_hit) begin
                    state_d = ERR_WAIT_EOP;
                end
            end
            STORE:   state_d = w_enable_q ? DATA_WAIT : ERR_WAIT_EOP;
            EOP_CHK: begin
                if (byte_count_q == 7'd0)      state_d = DONE;
                else if (byte_count_q == 7'd1) state_d = ERR_WAIT_EOP;
                else if (rx.crc_ok)            state_d = DONE;
                else                           state_d = ERR_WAIT_EOP;
            end
            DONE:         state_d = IDLE;
            ERR_WAIT_EOP: if (rx.eop)  state_d = ERR_IDLE;
            ERR_IDLE:     if (!rx.eop) state_d = IDLE;
            default:      state_d = IDLE;
        endcase

        if (state_d == ERR_WAIT_EOP) r_error_d = 1'b1;

        rcving_d = (state_d != IDLE) && (state_d != DONE) && (state_d != ERR_IDLE);
        // CRC keeps accumulating through STORE so no bit strobe of the payload is dropped.
        crc_enable_d  = (state_d == DATA_WAIT) || (state_d == STORE);
        packet_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            rcving_q      <= 1'b0;
            w_enable_q    <= 1'b0;
            r_error_q     <= 1'b0;
            rx_pid_q      <= 4'h0;
            packet_done_q <= 1'b0;
            crc_clear_q   <= 1'b0;
            crc_enable_q  <= 1'b0;
            byte_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            rcving_q      <= rcving_d;
            w_enable_q    <= w_enable_d;
            r_error_q     <= r_error_d;
            rx_pid_q      <= rx_pid_d;
            packet_done_q <= packet_done_d;
            crc_clear_q   <= crc_clear_d;
            crc_enable_q  <= crc_enable_d;
            byte_count_q  <= byte_count_d;
        end
    end

    assign rx.rcving      = rcving_q;
    assign rx.w_enable    = w_enable_q;
    assign rx.r_error     = r_error_q;
    assign rx.rx_pid      = rx_pid_q;
    assign rx.packet_done = packet_done_q;
    assign rx.crc_clear   = crc_clear_q;
    assign rx.crc_enable  = crc_enable_q;
    assign rx.byte_count  = byte_count_q;
    assign rx.state_dbg   = state_q;
endmodule

// File: tb/tb_usb_rx_controller.sv
// Directed bench for usb_rx_controller: packet-level model predicts FIFO writes, PID, error and
// byte count; a negedge monitor scoreboards every write and packet_done against it.
module tb_usb_rx_controller;
    localparam int MAX_BYTES = 64;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    usb_rx_controller_if bus ();

    usb_rx_controller dut (
        .clk   (clk),
        .n_rst (n_rst),
        .rx    (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pkt_q[$];
    int         done_seen = 0;
    int         wr_seen   = 0;

    logic [3:0] m_pid = 4'h0;
    logic       m_err = 1'b0;
    logic [6:0] m_cnt = 7'd0;
    logic       m_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (bus.w_enable) begin
                wr_seen++;
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("write_data", 32'(bus.rcv_data), 32'(exp_q.pop_front()));
            end
            if (bus.packet_done) begin
                done_seen++;
                check("done_r_error", 32'(bus.r_error), 32'd0);
                check("done_rcving", 32'(bus.rcving), 32'd0);
            end
            check("byte_count_bound", 32'(bus.byte_count <= 7'(MAX_BYTES)), 32'd1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Packet-level view: first byte SYNC, second PID, the rest payload (CRC bytes included).
    task automatic model_packet(input bit crc, input int full_idx);
        bit err;
        err    = 1'b0;
        m_done = 1'b0;
        m_cnt  = 7'd0;
        if (pkt_q.size() < 1 || pkt_q[0] != 8'h80) begin
            err = 1'b1;
        end else begin
            m_err = 1'b0;
            if (pkt_q.size() < 2 || pkt_q[1][7:4] != ~pkt_q[1][3:0]) begin
                err = 1'b1;
            end else begin
                m_pid = pkt_q[1][3:0];
                for (int i = 2; i < pkt_q.size() && !err; i++) begin
                    if ((full_idx >= 0 && i - 2 >= full_idx) || int'(m_cnt) == MAX_BYTES) begin
                        err = 1'b1;
                    end else begin
                        exp_q.push_back(pkt_q[i]);
                        m_cnt = m_cnt + 7'd1;
                    end
                end
                if (!err) begin
                    if (m_cnt == 7'd1 || (m_cnt >= 7'd2 && !crc)) err = 1'b1;
                    else m_done = 1'b1;
                end
            end
        end
        if (err) m_err = 1'b1;
    endtask

    task automatic send_bits(input int n);
        for (int k = 0; k < n; k++) begin
            bus.shift_enable = 1'b1;
            tick(1);
            bus.shift_enable = 1'b0;
            tick(2);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(8);
        bus.rcv_data      = b;
        bus.byte_received = 1'b1;
        tick(1);
        bus.byte_received = 1'b0;
        tick(2);
    endtask

    task automatic start_packet();
        done_seen  = 0;
        wr_seen    = 0;
        bus.d_edge = 1'b1;
        tick(1);
        bus.d_edge = 1'b0;
        tick(2);
    endtask

    task automatic run_packet(input bit crc, input int full_idx, input bit probe_err_idle);
        model_packet(crc, full_idx);
        start_packet();
        foreach (pkt_q[i]) begin
            if (full_idx >= 0 && i - 2 == full_idx) bus.fifo_full = 1'b1;
            send_byte(pkt_q[i]);
        end
        bus.crc_ok = crc;
        bus.eop    = 1'b1;
        if (probe_err_idle) begin
            tick(2);
            bus.d_edge = 1'b1;
            tick(1);
            bus.d_edge = 1'b0;
            check("err_idle_ignores_d_edge", 32'(bus.rcving), 32'd0);
            tick(1);
        end else begin
            tick(4);
        end
        bus.eop = 1'b0;
        tick(4);
        bus.fifo_full = 1'b0;
        bus.crc_ok    = 1'b0;
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_r_error"}, 32'(bus.r_error), 32'(m_err));
        check({tag, "_rx_pid"}, 32'(bus.rx_pid), 32'(m_pid));
        check({tag, "_byte_count"}, 32'(bus.byte_count), 32'(m_cnt));
        check({tag, "_packet_done"}, 32'(done_seen), 32'(m_done));
        check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_rcving_idle"}, 32'(bus.rcving), 32'd0);
    endtask

    initial begin
        n_rst             = 1'b0;
        bus.d_edge        = 1'b0;
        bus.eop           = 1'b0;
        bus.shift_enable  = 1'b0;
        bus.byte_received = 1'b0;
        bus.rcv_data      = 8'h00;
        bus.crc_ok        = 1'b0;
        bus.fifo_full     = 1'b0;
        tick(3);
        check("rst_rcving", 32'(bus.rcving), 32'd0);
        check("rst_w_enable", 32'(bus.w_enable), 32'd0);
        check("rst_r_error", 32'(bus.r_error), 32'd0);
        check("rst_rx_pid", 32'(bus.rx_pid), 32'd0);
        check("rst_packet_done", 32'(bus.packet_done), 32'd0);
        check("rst_crc_clear", 32'(bus.crc_clear), 32'd0);
        check("rst_crc_enable", 32'(bus.crc_enable), 32'd0);
        check("rst_byte_count", 32'(bus.byte_count), 32'd0);
        n_rst = 1'b1;
        tick(2);

        pkt_q = '{8'h80, 8'hC3, 8'h01, 8'h02};
        run_packet(1'b1, -1, 1'b0);
        end_checks("two_bytes");
        check("two_bytes_lit_pid", 32'(bus.rx_pid), 32'h3);
        check("two_bytes_lit_count", 32'(bus.byte_count), 32'd2);
        check("two_bytes_lit_writes", 32'(wr_seen), 32'd2);

        pkt_q = '{8'h80, 8'hD2};
        run_packet(1'b0, -1, 1'b0);
        end_checks("handshake");
        check("handshake_lit_pid", 32'(bus.rx_pid), 32'h2);
        check("handshake_lit_writes", 32'(wr_seen), 32'd0);
        check("handshake_lit_done", 32'(done_seen), 32'd1);

        pkt_q = '{8'h81, 8'hC3, 8'h01};
        run_packet(1'b1, -1, 1'b1);
        end_checks("bad_sync");
        check("bad_sync_lit_err", 32'(bus.r_error), 32'd1);

        pkt_q = '{8'h80, 8'hC4, 8'h55};
        run_packet(1'b1, -1, 1'b0);
        end_checks("bad_pid");
        check("bad_pid_lit_pid", 32'(bus.rx_pid), 32'h2);

        pkt_q = '{8'h80, 8'hA5, 8'h11, 8'h22, 8'h33};
        run_packet(1'b1, 1, 1'b0);
        end_checks("fifo_full");
        check("fifo_full_lit_writes", 32'(wr_seen), 32'd1);

        pkt_q = '{8'h80, 8'hE1, 8'hAA, 8'hBB};
        run_packet(1'b0, -1, 1'b0);
        end_checks("crc_bad");
        check("crc_bad_lit_err", 32'(bus.r_error), 32'd1);

        pkt_q = '{8'h80, 8'h4B, 8'h7E};
        run_packet(1'b1, -1, 1'b0);
        end_checks("one_byte");

        pkt_q = '{8'h80, 8'hC3};
        for (int i = 0; i < MAX_BYTES + 1; i++) pkt_q.push_back(8'(i + 1));
        run_packet(1'b1, -1, 1'b0);
        end_checks("overflow");
        check("overflow_lit_count", 32'(bus.byte_count), 32'd64);
        check("overflow_lit_writes", 32'(wr_seen), 32'd64);

        // Sixteen bit strobes after the PID with no byte following.
        start_packet();
        send_byte(8'h80);
        send_byte(8'hC3);
        send_bits(16);
        tick(2);
`ifdef USB_RX_TIMEOUT_EN
        check("timeout_err", 32'(bus.r_error), 32'd1);
        m_err  = 1'b1;
        m_done = 1'b0;
`else
        check("no_timeout_err", 32'(bus.r_error), 32'd0);
        m_err  = 1'b0;
        m_done = 1'b1;
`endif
        check("timeout_rcving", 32'(bus.rcving), 32'd1);
        m_pid   = 4'h3;
        m_cnt   = 7'd0;
        bus.eop = 1'b1;
        tick(4);
        bus.eop = 1'b0;
        tick(4);
        end_checks("strobe_gap");

        pkt_q = '{8'h80, 8'h69, 8'h10, 8'h20, 8'h30};
        run_packet(1'b1, -1, 1'b0);
        end_checks("recover");
        check("recover_lit_err", 32'(bus.r_error), 32'd0);
        check("recover_lit_pid", 32'(bus.rx_pid), 32'h9);

        start_packet();
        send_byte(8'h80);
        send_byte(8'hC3);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A);
        send_bits(4);
        n_rst = 1'b0;
        #2;
        check("midrst_rcving", 32'(bus.rcving), 32'd0);
        check("midrst_w_enable", 32'(bus.w_enable), 32'd0);
        check("midrst_r_error", 32'(bus.r_error), 32'd0);
        check("midrst_rx_pid", 32'(bus.rx_pid), 32'h0);
        check("midrst_crc_enable", 32'(bus.crc_enable), 32'd0);
        check("midrst_byte_count", 32'(bus.byte_count), 32'd0);
        check("midrst_writes", 32'(wr_seen), 32'd1);
        check("midrst_writes_left", 32'(exp_q.size()), 32'd0);
        tick(2);
        n_rst = 1'b1;
        m_pid = 4'h0;
        m_err = 1'b0;
        tick(2);

        pkt_q = '{8'h80, 8'hD2};
        run_packet(1'b0, -1, 1'b0);
        end_checks("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
